// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: state encoding and ALU opcode constants shared by the
// ALU arbiter, its round-robin grant logic and the surrounding bench.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] FWD = 3'b000;
    localparam logic [2:0] ADD = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;

    localparam int CNT_W = 4;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester and ALU-side bundle of the ALU arbiter.
// master = requesters + external alu, slave = the arbiter.
interface alu_arbiter_if;

    logic       REQ0;
    logic       REQ1;
    logic [2:0] SELECT0;
    logic [2:0] SELECT1;
    logic [7:0] OPA0;
    logic [7:0] OPB0;
    logic [7:0] OPA1;
    logic [7:0] OPB1;
    logic       ACK0;
    logic       ACK1;
    logic [7:0] RESULT_OUT;
    logic       ZERO_OUT;
    logic       BUSY;
    logic [7:0] ALU_DATA1;
    logic [7:0] ALU_DATA2;
    logic [2:0] ALU_SELECT;
    logic [7:0] ALU_RESULT;
    logic       ALU_ZERO;

    modport master (
        output REQ0, REQ1, SELECT0, SELECT1,
        output OPA0, OPB0, OPA1, OPB1,
        output ALU_RESULT, ALU_ZERO,
        input  ACK0, ACK1, RESULT_OUT, ZERO_OUT, BUSY,
        input  ALU_DATA1, ALU_DATA2, ALU_SELECT
    );

    modport slave (
        input  REQ0, REQ1, SELECT0, SELECT1,
        input  OPA0, OPB0, OPA1, OPB1,
        input  ALU_RESULT, ALU_ZERO,
        output ACK0, ACK1, RESULT_OUT, ZERO_OUT, BUSY,
        output ALU_DATA1, ALU_DATA2, ALU_SELECT
    );

endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational 2-way round-robin grant.
// Ports: REQ0/REQ1 requests, PRIO favoured requester, GRANT one-hot.
module rr_arbiter2 (
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       PRIO,
    output logic [1:0] GRANT
);

    always_comb begin
        GRANT = 2'b00;
        unique case (1'b1)
            (REQ0 && REQ1):  GRANT = PRIO ? 2'b10 : 2'b01;
            (REQ0 && !REQ1): GRANT = 2'b01;
            (!REQ0 && REQ1): GRANT = 2'b10;
            default:         GRANT = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external alu between two requesters.
// Ports: CLK, RESET (sync, active-low), bus (requests, acks, alu drive).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input logic         CLK,
    input logic         RESET,
    alu_arbiter_if.slave bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             prio;
    logic             winner;
    logic [1:0]       grant;
    logic             ack0;
    logic             ack1;
    logic [7:0]       result_out;
    logic             zero_out;
    logic [7:0]       alu_data1;
    logic [7:0]       alu_data2;
    logic [2:0]       alu_select;

    rr_arbiter2 u_rr (
        .REQ0  (bus.REQ0),
        .REQ1  (bus.REQ1),
        .PRIO  (prio),
        .GRANT (grant)
    );

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state      <= IDLE;
            cnt        <= '0;
            prio       <= 1'b0;
            winner     <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            result_out <= '0;
            zero_out   <= 1'b0;
            alu_data1  <= '0;
            alu_data2  <= '0;
            alu_select <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        winner     <= grant[1];
                        alu_select <= grant[1] ? bus.SELECT1 : bus.SELECT0;
                        alu_data1  <= grant[1] ? bus.OPA1 : bus.OPA0;
                        alu_data2  <= grant[1] ? bus.OPB1 : bus.OPB0;
                        cnt        <= CNT_W'(SETTLE_CYCLES);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    // Last settle cycle: alu output is stable, capture it.
                    if (cnt == CNT_W'(1)) begin
                        result_out <= bus.ALU_RESULT;
                        zero_out   <= bus.ALU_ZERO;
                        ack0       <= ~winner;
                        ack1       <= winner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    prio  <= ~winner;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ACK0       = ack0;
    assign bus.ACK1       = ack1;
    assign bus.RESULT_OUT = result_out;
    assign bus.ZERO_OUT   = zero_out;
    assign bus.BUSY       = (state != IDLE);
    assign bus.ALU_DATA1  = alu_data1;
    assign bus.ALU_DATA2  = alu_data2;
    assign bus.ALU_SELECT = alu_select;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with SETTLE_CYCLES
// of 1 and 3, each driving a behavioural alu.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    typedef struct {
        bit         port;
        logic [7:0] res;
        logic       zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   both_ack = 1'b0;
    exp_t sb[$];

    alu_arbiter_if b1();
    alu_arbiter_if b3();

    always #5 clk = ~clk;

    alu_arbiter #(.SETTLE_CYCLES(1)) dut1 (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (b1.slave)
    );

    alu_arbiter #(.SETTLE_CYCLES(3)) dut3 (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (b3.slave)
    );

    function automatic logic [7:0] alu_res(input logic [2:0] s,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        case (s)
            ADD:     return a + b;
            AND:     return a & b;
            OR:      return a | b;
            default: return b;
        endcase
    endfunction

    function automatic logic alu_zero(input logic [7:0] a,
                                      input logic [7:0] b);
        logic [7:0] t;
        t = a + b;
        return (t == 8'h00);
    endfunction

    assign b1.ALU_RESULT = alu_res(b1.ALU_SELECT, b1.ALU_DATA1, b1.ALU_DATA2);
    assign b1.ALU_ZERO   = alu_zero(b1.ALU_DATA1, b1.ALU_DATA2);
    assign b3.ALU_RESULT = alu_res(b3.ALU_SELECT, b3.ALU_DATA1, b3.ALU_DATA2);
    assign b3.ALU_ZERO   = alu_zero(b3.ALU_DATA1, b3.ALU_DATA2);

    always @(negedge clk) begin
        if ((b1.ACK0 && b1.ACK1) || (b3.ACK0 && b3.ACK1))
            both_ack = 1'b1;
    end

    task automatic drive(input bit use3, input bit port, input logic [2:0] s,
                         input logic [7:0] a, input logic [7:0] b);
        if (!use3 && !port) begin
            b1.REQ0 = 1'b1; b1.SELECT0 = s; b1.OPA0 = a; b1.OPB0 = b;
        end else if (!use3) begin
            b1.REQ1 = 1'b1; b1.SELECT1 = s; b1.OPA1 = a; b1.OPB1 = b;
        end else if (!port) begin
            b3.REQ0 = 1'b1; b3.SELECT0 = s; b3.OPA0 = a; b3.OPB0 = b;
        end else begin
            b3.REQ1 = 1'b1; b3.SELECT1 = s; b3.OPA1 = a; b3.OPB1 = b;
        end
    endtask

    // Waits for an ACK; lat counts falling edges since the call, so an
    // op granted at the next rising edge acks at lat = SETTLE_CYCLES+1.
    task automatic wait_ack(input bit use3, input bit drop, input int max,
                            output bit got, output int lat, output bit port,
                            output logic [7:0] res, output logic z,
                            output bit stable);
        logic [18:0] alu0;
        logic [18:0] cur;
        logic        a0;
        logic        a1;
        got = 1'b0; lat = 0; port = 1'b0; res = '0; z = 1'b0;
        stable = 1'b1; alu0 = '0;
        for (int i = 1; i <= max && !got; i++) begin
            @(negedge clk);
            lat = i;
            cur = use3 ? {b3.ALU_SELECT, b3.ALU_DATA1, b3.ALU_DATA2}
                       : {b1.ALU_SELECT, b1.ALU_DATA1, b1.ALU_DATA2};
            if (i == 1) alu0 = cur;
            else if (cur !== alu0) stable = 1'b0;
            if (drop && i == 1) begin
                if (use3) begin b3.REQ0 = 1'b0; b3.REQ1 = 1'b0; end
                else begin b1.REQ0 = 1'b0; b1.REQ1 = 1'b0; end
            end
            a0 = use3 ? b3.ACK0 : b1.ACK0;
            a1 = use3 ? b3.ACK1 : b1.ACK1;
            if (a0 || a1) begin
                got  = 1'b1;
                port = a1;
                res  = use3 ? b3.RESULT_OUT : b1.RESULT_OUT;
                z    = use3 ? b3.ZERO_OUT : b1.ZERO_OUT;
            end
        end
    endtask

    task automatic test_reset();
        logic [29:0] v;
        rst_n = 1'b0;
        b1.REQ0 = 1'b1;
        repeat (3) @(negedge clk);
        v = {b1.ACK0, b1.ACK1, b1.RESULT_OUT, b1.ZERO_OUT, b1.ALU_DATA1,
             b1.ALU_DATA2[3:0], b1.ALU_SELECT, b1.BUSY};
        total++;
        if (v !== '0 || b1.ALU_DATA2 !== 8'h00) begin
            bad++; $display("FAIL reset_dut1 got=%h want=0", v);
        end
        v = {b3.ACK0, b3.ACK1, b3.RESULT_OUT, b3.ZERO_OUT, b3.ALU_DATA1,
             b3.ALU_DATA2[3:0], b3.ALU_SELECT, b3.BUSY};
        total++;
        if (v !== '0 || b3.ALU_DATA2 !== 8'h00) begin
            bad++; $display("FAIL reset_dut3 got=%h want=0", v);
        end
        b1.REQ0 = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        exp_t e; bit got; int lat; bit port; logic [7:0] res; logic z; bit st;
        drive(1'b0, 1'b0, ADD, 8'h05, 8'h03);
        sb.push_back('{1'b0, 8'h08, 1'b0});
        wait_ack(1'b0, 1'b1, 8, got, lat, port, res, z, st);
        e = sb.pop_front();
        total++;
        if (!got) begin bad++; $display("FAIL add_ack got=0 want=1"); end
        total++;
        if (port !== e.port) begin
            bad++; $display("FAIL add_port got=%0d want=%0d", port, e.port);
        end
        total++;
        if (res !== e.res) begin
            bad++; $display("FAIL add_result got=%h want=%h", res, e.res);
        end
        total++;
        if (z !== e.zero) begin
            bad++; $display("FAIL add_zero got=%b want=%b", z, e.zero);
        end
        total++;
        if (lat !== 2) begin
            bad++; $display("FAIL add_latency got=%0d want=2", lat);
        end
        @(negedge clk);
        total++;
        if ({b1.ACK0, b1.BUSY} !== 2'b00) begin
            bad++; $display("FAIL add_ack_clear got=%b want=00", {b1.ACK0, b1.BUSY});
        end
        repeat (3) @(negedge clk);
        total++;
        if (b1.RESULT_OUT !== 8'h08) begin
            bad++; $display("FAIL add_hold got=%h want=08", b1.RESULT_OUT);
        end
    endtask

    task automatic test_round_robin();
        exp_t e; bit got; int lat; bit port; logic [7:0] res; logic z; bit st;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, AND, 8'hF0, 8'h3C);
        drive(1'b0, 1'b1, OR, 8'hF0, 8'h0F);
        repeat (2) @(negedge clk);
        total++;
        if (b1.BUSY !== 1'b0) begin
            bad++; $display("FAIL rr_req_in_reset busy got=%b want=0", b1.BUSY);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (n % 2 == 1) sb.push_back('{1'b1, 8'hFF, 1'b0});
            else sb.push_back('{1'b0, 8'h30, 1'b0});
            wait_ack(1'b0, 1'b0, 8, got, lat, port, res, z, st);
            e = sb.pop_front();
            if (n == 3) begin b1.REQ0 = 1'b0; b1.REQ1 = 1'b0; end
            total++;
            if (!got || port !== e.port) begin
                bad++; $display("FAIL rr_port%0d got=%0d/%0d want=1/%0d", n, got, port, e.port);
            end
            total++;
            if (res !== e.res || z !== e.zero) begin
                bad++; $display("FAIL rr_result%0d got=%h/%b want=%h/%b", n, res, z, e.res, e.zero);
            end
            total++;
            if (lat !== ((n == 0) ? 2 : 3)) begin
                bad++; $display("FAIL rr_latency%0d got=%0d want=%0d", n, lat, (n == 0) ? 2 : 3);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_fwd();
        exp_t e; bit got; int lat; bit port; logic [7:0] res; logic z; bit st;
        drive(1'b0, 1'b1, FWD, 8'h01, 8'hFF);
        sb.push_back('{1'b1, 8'hFF, 1'b1});
        wait_ack(1'b0, 1'b1, 8, got, lat, port, res, z, st);
        e = sb.pop_front();
        total++;
        if (!got || port !== e.port) begin
            bad++; $display("FAIL fwd_port got=%0d/%0d want=1/%0d", got, port, e.port);
        end
        total++;
        if (res !== e.res) begin
            bad++; $display("FAIL fwd_result got=%h want=%h", res, e.res);
        end
        total++;
        if (z !== e.zero) begin
            bad++; $display("FAIL fwd_zero got=%b want=%b", z, e.zero);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_abort();
        exp_t e; bit got; int lat; bit port; logic [7:0] res; logic z; bit st;
        bit seen;
        logic [29:0] v;
        drive(1'b0, 1'b0, ADD, 8'h05, 8'h03);
        @(negedge clk);
        total++;
        if (b1.BUSY !== 1'b1) begin
            bad++; $display("FAIL abort_busy got=%b want=1", b1.BUSY);
        end
        rst_n = 1'b0;
        b1.REQ0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (b1.ACK0 || b1.ACK1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL abort_no_ack got=%b want=0", seen);
        end
        v = {b1.ACK0, b1.ACK1, b1.RESULT_OUT, b1.ZERO_OUT, b1.ALU_DATA1,
             b1.ALU_DATA2[3:0], b1.ALU_SELECT, b1.BUSY};
        total++;
        if (v !== '0 || b1.ALU_DATA2 !== 8'h00) begin
            bad++; $display("FAIL abort_outputs got=%h want=0", v);
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b1, ADD, 8'h10, 8'h20);
        sb.push_back('{1'b1, 8'h30, 1'b0});
        wait_ack(1'b0, 1'b1, 8, got, lat, port, res, z, st);
        e = sb.pop_front();
        total++;
        if (!got || port !== e.port || lat !== 2) begin
            bad++; $display("FAIL abort_next got=%0d/%0d/%0d want=1/%0d/2", got, port, lat, e.port);
        end
        total++;
        if (res !== e.res || z !== e.zero) begin
            bad++; $display("FAIL abort_next_result got=%h/%b want=%h/%b", res, z, e.res, e.zero);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_passthru();
        exp_t e; bit got; int lat; bit port; logic [7:0] res; logic z; bit st;
        drive(1'b0, 1'b0, 3'b111, 8'h12, 8'h5A);
        sb.push_back('{1'b0, 8'h5A, 1'b0});
        wait_ack(1'b0, 1'b1, 8, got, lat, port, res, z, st);
        e = sb.pop_front();
        total++;
        if (!got || port !== e.port) begin
            bad++; $display("FAIL pass_ack got=%0d/%0d want=1/%0d", got, port, e.port);
        end
        total++;
        if (res !== e.res || z !== e.zero) begin
            bad++; $display("FAIL pass_result got=%h/%b want=%h/%b", res, z, e.res, e.zero);
        end
        total++;
        if (b1.ALU_SELECT !== 3'b111) begin
            bad++; $display("FAIL pass_select got=%b want=111", b1.ALU_SELECT);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_settle3();
        exp_t e; bit got; int lat; bit port; logic [7:0] res; logic z; bit st;
        drive(1'b1, 1'b1, ADD, 8'h80, 8'h80);
        sb.push_back('{1'b1, 8'h00, 1'b1});
        wait_ack(1'b1, 1'b1, 12, got, lat, port, res, z, st);
        e = sb.pop_front();
        total++;
        if (!got || port !== e.port) begin
            bad++; $display("FAIL s3_ack got=%0d/%0d want=1/%0d", got, port, e.port);
        end
        total++;
        if (lat !== 4) begin
            bad++; $display("FAIL s3_latency got=%0d want=4", lat);
        end
        total++;
        if (res !== e.res || z !== e.zero) begin
            bad++; $display("FAIL s3_result got=%h/%b want=%h/%b", res, z, e.res, e.zero);
        end
        total++;
        if (st !== 1'b1) begin
            bad++; $display("FAIL s3_alu_stable got=%b want=1", st);
        end
        @(negedge clk);
        total++;
        if (b3.ACK1 !== 1'b0) begin
            bad++; $display("FAIL s3_ack_pulse got=%b want=0", b3.ACK1);
        end
    endtask

    task automatic test_ack_exclusive();
        total++;
        if (both_ack !== 1'b0) begin
            bad++; $display("FAIL ack_exclusive got=%b want=0", both_ack);
        end
    endtask

    initial begin
        b1.REQ0 = 1'b0; b1.REQ1 = 1'b0; b1.SELECT0 = '0; b1.SELECT1 = '0;
        b1.OPA0 = '0; b1.OPB0 = '0; b1.OPA1 = '0; b1.OPB1 = '0;
        b3.REQ0 = 1'b0; b3.REQ1 = 1'b0; b3.SELECT0 = '0; b3.SELECT1 = '0;
        b3.OPA0 = '0; b3.OPB0 = '0; b3.OPA1 = '0; b3.OPB1 = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_round_robin();
        test_fwd();
        test_reset_abort();
        test_passthru();
        test_settle3();
        test_ack_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1: cycles ALU inputs are held before the result is captured; legal range 1..15.
REQ-002 SHALL have port CLK, input, 1: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have ports REQ0 / REQ1, input, 1 each: requester n wants one ALU operation.
REQ-005 SHALL have ports SELECT0 / SELECT1, input, 3 each: requester n ALU opcode.
REQ-006 SHALL have ports OPA0, OPB0, OPA1, OPB1, input, 8 each: requester n operands (DATA1, DATA2).
REQ-007 SHALL have ports ACK0 / ACK1, output, 1 each: one-cycle pulse, requester n result valid.
REQ-008 SHALL have port RESULT_OUT, output, 8: captured ALU result.
REQ-009 SHALL have port ZERO_OUT, output, 1: captured ALU ZERO flag.
REQ-010 SHALL have port BUSY, output, 1: high whenever state is not IDLE.
REQ-011 SHALL have ports ALU_DATA1 / ALU_DATA2, output, 8 each, and ALU_SELECT, output, 3: registered drive to the alu instance.
REQ-012 SHALL have ports ALU_RESULT, input, 8, and ALU_ZERO, input, 1: returned from the alu instance.

Function
REQ-013 SHALL implement states IDLE, WAIT and DONE.
REQ-014 In IDLE, at an edge with any REQn high, SHALL choose one winner, register its SELECTn/OPAn/OPBn onto ALU_SELECT/ALU_DATA1/ALU_DATA2, load CNT=SETTLE_CYCLES and go to WAIT.
REQ-015 In WAIT, each edge SHALL decrement CNT; at the edge where CNT==1, SHALL capture ALU_RESULT->RESULT_OUT and ALU_ZERO->ZERO_OUT, set ACK(winner)=1 and go to DONE.
REQ-016 In DONE, SHALL clear ACK, update the priority pointer and go to IDLE; a new grant is possible only from IDLE.
REQ-017 Timing: for a grant at edge k, ACKn SHALL be high for exactly the cycle after edge k+SETTLE_CYCLES; throughput SHALL be one op per SETTLE_CYCLES+2 cycles.
REQ-018 ALU_* outputs SHALL be held stable from grant through DONE; CLK period SHALL exceed the alu's worst path delay (2 time units).
REQ-019 Arbitration: round-robin pointer PRIO; when both request, PRIO wins; a lone request wins regardless of PRIO; after completion PRIO = the non-winner.
REQ-020 Operands SHALL be sampled only at grant; later changes, including REQn dropping mid-op, SHALL NOT abort the op, and ACKn still pulses.
REQ-021 A requester holding REQn high after its ACK SHALL be treated as a new request.
REQ-022 SELECT codes 100-111 SHALL be passed through unmodified; the alu forwards DATA2 for them.
REQ-023 ZERO_OUT SHALL mirror ALU_ZERO as captured, which reflects DATA1+DATA2==0 regardless of SELECT.
REQ-024 RESULT_OUT/ZERO_OUT SHALL hold their last captured values until the next capture.
REQ-025 ACK0 and ACK1 SHALL never be high in the same cycle.

Reset
REQ-026 RESET low at an edge SHALL force: state IDLE, CNT=0, PRIO=0, ACK0=ACK1=0, RESULT_OUT=0, ZERO_OUT=0, ALU_DATA1=ALU_DATA2=0, ALU_SELECT=0, BUSY=0.
REQ-027 Reset during WAIT or DONE SHALL abort the op with no ACK.
REQ-028 REQn sampled during reset SHALL be ignored; arbitration SHALL resume at the first edge with RESET high.

Structure
REQ-029 Package alu_arb_pkg SHALL hold the state encoding (IDLE/WAIT/DONE) and opcode constants: FWD=000, ADD=001, AND=010, OR=011.
REQ-030 The 2-way round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs REQ0, REQ1, PRIO; one-hot grant output); the alu itself SHALL be instantiated outside this block.

Verification
REQ-031 SETTLE_CYCLES=1, REQ0 ADD 8'h05,8'h03 -> ACK0 one cycle after edge k+1, RESULT_OUT=8'h08, ZERO_OUT=0.
REQ-032 REQ0 and REQ1 held high from reset, REQ0 AND F0,3C, REQ1 OR F0,0F -> ACKs alternate ACK0, ACK1, ACK0...; results 8'h30 and 8'hFF.
REQ-033 REQ1 SELECT=000, OPA=8'h01, OPB=8'hFF -> RESULT_OUT=8'hFF, ZERO_OUT=1.
REQ-034 REQ0 ADD issued, RESET low during WAIT -> no ACK, all outputs 0; next REQ1 is served first.
REQ-035 SETTLE_CYCLES=3, REQ1 ADD 8'h80,8'h80 -> ACK1 one cycle after edge k+3, ALU_* stable throughout, RESULT_OUT=8'h00, ZERO_OUT=1.
REQ-036 REQ0 SELECT=3'b111, OPB=8'h5A, REQ0 dropped after grant -> ACK0 still pulses, RESULT_OUT=8'h5A.
